// File: rtl/aes_mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns engine: LANES result bytes per cycle,
// valid/ready on both sides, run-time forward/inverse selection.
module aes_mixcol_engine #(
    parameter int LANES  = 1,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv_mode,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    localparam int CYCLES = 16 / LANES;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [127:0]       in_reg, in_next;
    logic [127:0]       result_reg, result_next;
    logic               mode_reg, mode_next;
    logic               inv_eff;
    logic               capture;
    logic [7:0]         lane_byte [LANES];
    logic [3:0]         lane_idx  [LANES];

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("aes_mixcol_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiply by the matrix coefficient selected by its first-row position.
    function automatic logic [7:0] cmul(input logic [7:0] a, input logic [1:0] idx, input logic inv);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        r  = a;
        if (inv) begin
            case (idx)
                2'd0:    r = x8 ^ x4 ^ x2;      // 0e
                2'd1:    r = x8 ^ x2 ^ a;       // 0b
                2'd2:    r = x8 ^ x4 ^ a;       // 0d
                default: r = x8 ^ a;            // 09
            endcase
        end else begin
            case (idx)
                2'd0:    r = x2;                // 02
                2'd1:    r = x2 ^ a;            // 03
                default: r = a;                 // 01
            endcase
        end
        return r;
    endfunction

    // Row r of the circulant matrix is the first row rotated right by r,
    // so column k uses first-row entry (k - r) mod 4.
    function automatic logic [7:0] mix_byte(input logic [31:0] col, input logic [1:0] row, input logic inv);
        logic [7:0] acc;
        logic [1:0] idx;
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
            idx = 2'(k) - row;
            acc ^= cmul(col[8*k +: 8], idx, inv);
        end
        return acc;
    endfunction

    assign inv_eff = (INV_EN != 0) && mode_reg;
    assign capture = (state_reg == IDLE) && in_valid;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] col_bytes;
            assign lane_idx[gi]  = 4'(int'(cnt_reg) * LANES + gi);
            assign col_bytes     = in_reg[{lane_idx[gi][3:2], 5'b00000} +: 32];
            assign lane_byte[gi] = mix_byte(col_bytes, lane_idx[gi][1:0], inv_eff);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            in_reg     <= '0;
            result_reg <= '0;
            mode_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            in_reg     <= in_next;
            result_reg <= result_next;
            mode_reg   <= mode_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt_reg == CNT_W'(CYCLES - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next    = cnt_reg;
        in_next     = in_reg;
        mode_next   = mode_reg;
        result_next = result_reg;
        if (capture) begin
            cnt_next    = '0;
            in_next     = state_in;
            mode_next   = (INV_EN != 0) ? inv_mode : 1'b0;
            result_next = '0;
        end else if (state_reg == CALC) begin
            cnt_next = (cnt_reg == CNT_W'(CYCLES - 1)) ? '0 : cnt_reg + 1'b1;
            for (int l = 0; l < LANES; l++) begin
                result_next[{lane_idx[l], 3'b000} +: 8] = lane_byte[l];
            end
        end
    end

    // in_ready is gated by reset so it stays low while reset is held.
    always_comb begin
        in_ready  = (state_reg == IDLE) && reset;
        out_valid = (state_reg == DONE);
        state_out = result_reg;
    end

endmodule

// File: tb/tb_aes_mixcol_engine.sv
// Scoreboard bench for aes_mixcol_engine: one instance per legal LANES plus a
// forward-only instance; expectations come from a shift-and-add GF(2^8) model.
module tb_aes_mixcol_engine;

    localparam int ND = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [ND-1:0] vld = '0;
    logic [ND-1:0] rdy;
    logic [ND-1:0] mode_s = '0;
    logic [ND-1:0] ov;
    logic [ND-1:0] ordy = '0;
    logic [127:0] data [ND];
    logic [127:0] so   [ND];

    logic [127:0] sb_q [$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dut
            aes_mixcol_engine #(.LANES(1 << gi), .INV_EN(1)) u_dut (
                .clk(clk), .reset(reset),
                .in_valid(vld[gi]), .in_ready(rdy[gi]), .inv_mode(mode_s[gi]),
                .state_in(data[gi]), .out_valid(ov[gi]), .out_ready(ordy[gi]),
                .state_out(so[gi])
            );
        end
    endgenerate

    aes_mixcol_engine #(.LANES(4), .INV_EN(0)) u_dut_fwd (
        .clk(clk), .reset(reset),
        .in_valid(vld[5]), .in_ready(rdy[5]), .inv_mode(mode_s[5]),
        .state_in(data[5]), .out_valid(ov[5]), .out_ready(ordy[5]),
        .state_out(so[5])
    );

    function automatic int cycles_of(input int d);
        return (d < 5) ? (16 >> d) : 4;
    endfunction

    function automatic bit inv_of(input int d);
        return d != 5;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int idx, input bit inv);
        logic [7:0] fwd [4];
        logic [7:0] rev [4];
        fwd = '{8'h02, 8'h03, 8'h01, 8'h01};
        rev = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        return inv ? rev[idx] : fwd[idx];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gf_mul(coef((k - r + 4) % 4, inv), s[8*(4*c+k) +: 8]);
                o[8*(4*c+r) +: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One handshaked operation: capture, latency, optional DONE hold with
    // in_valid pulses and inv_mode toggling during CALC, then release.
    task automatic do_op(input int d, input logic [127:0] st, input bit mode, input int hold,
                         input bit pulse, input bit toggle, output logic [127:0] res);
        logic [127:0] exp;
        int n, lat;
        res = '0;
        sb_q.push_back(model(st, mode && inv_of(d)));
        n = 0;
        while (!rdy[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", 128'(rdy[d]), 128'(1'b1));
        data[d]   = st;
        mode_s[d] = mode;
        vld[d]    = 1'b1;
        @(negedge clk);
        vld[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 40) begin
            if (toggle) mode_s[d] = ~mode_s[d];
            chk("in_ready_busy", 128'(rdy[d]), 128'(1'b0));
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'(cycles_of(d)));
        exp = sb_q.pop_front();
        if (!ov[d]) begin
            chk("out_valid_timeout", 128'(ov[d]), 128'(1'b1));
        end else begin
            res = so[d];
            chk("result", so[d], exp);
            for (int i = 0; i < hold; i++) begin
                vld[d]  = pulse && i[0];
                data[d] = ~st;
                @(negedge clk);
                chk("hold_valid", 128'(ov[d]), 128'(1'b1));
                chk("hold_ready", 128'(rdy[d]), 128'(1'b0));
                chk("hold_stable", so[d], exp);
            end
            vld[d]  = 1'b0;
            ordy[d] = 1'b1;
            @(negedge clk);
            ordy[d] = 1'b0;
            chk("release_valid", 128'(ov[d]), 128'(1'b0));
            chk("release_ready", 128'(rdy[d]), 128'(1'b1));
        end
        mode_s[d] = 1'b0;
    endtask

    // Streaming scoreboard; with rnd=0 inputs and out_ready are tied high and
    // the spacing between captures is checked.
    task automatic stream(input int d, input int n, input bit rnd);
        int cyc, done, sent, last_cap;
        cyc = 0; done = 0; sent = 0; last_cap = -1;
        while (done < n && cyc < n * 60) begin
            @(negedge clk);
            cyc++;
            vld[d]    = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            data[d]   = rand128();
            mode_s[d] = 1'($urandom);
            ordy[d]   = rnd ? 1'($urandom) : 1'b1;
            chk("excl", 128'(rdy[d] & ov[d]), 128'(1'b0));
            if (rdy[d] && vld[d]) begin
                sb_q.push_back(model(data[d], mode_s[d] && inv_of(d)));
                sent++;
                if (!rnd && last_cap >= 0) chk("period", 128'(cyc - last_cap), 128'(cycles_of(d) + 2));
                last_cap = cyc;
            end
            if (ov[d] && ordy[d]) begin
                if (sb_q.size() == 0) chk("sb_empty", 128'(1'b1), 128'(1'b0));
                else chk("stream_out", so[d], sb_q.pop_front());
                done++;
            end
        end
        chk("stream_count", 128'(done), 128'(n));
        @(negedge clk);
        vld[d]  = 1'b0;
        ordy[d] = 1'b0;
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t1, r1, r2, st;
        for (int d = 0; d < ND; d++) data[d] = '0;
        t1 = {32'h5cd4d4d4, 32'hc6c6c6c6, 32'h01010101, 32'h455313db};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(rdy), 128'(0));
        chk("rst_out_valid", 128'(ov), 128'(0));
        chk("rst_state_out", so[0], '0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 128'(rdy), 128'({ND{1'b1}}));

        // Known forward vector on LANES=1
        do_op(0, t1, 1'b0, 3, 1'b0, 1'b0, r1);
        chk("t1_col0", 128'(r1[31:0]), 128'(32'hbca14d8e));
        chk("t1_col1", 128'(r1[63:32]), 128'(32'h01010101));
        chk("t1_col2", 128'(r1[95:64]), 128'(32'hc6c6c6c6));
        chk("t1_col3", 128'(r1[127:96]), 128'(model(t1, 1'b0) >> 96));

        // Inverse round trip
        do_op(2, r1, 1'b1, 0, 1'b0, 1'b0, r2);
        chk("rt_l4", r2, t1);
        do_op(4, r1, 1'b1, 0, 1'b0, 1'b0, r2);
        chk("rt_l16", r2, t1);

        // Backpressure with in_valid pulses in DONE, then a fresh capture
        do_op(1, rand128(), 1'b0, 10, 1'b1, 1'b0, r2);
        do_op(1, rand128(), 1'b1, 0, 1'b0, 1'b0, r2);

        // Reset at cnt=7 on LANES=1
        st = rand128();
        @(negedge clk);
        data[0] = st;
        vld[0]  = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 128'(ov[0]), 128'(1'b0));
        chk("midrst_out", so[0], '0);
        chk("midrst_ready", 128'(rdy[0]), 128'(1'b0));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_release", 128'(rdy[0]), 128'(1'b1));
        do_op(0, st, 1'b1, 0, 1'b0, 1'b0, r2);

        // Mode latching and forward-only instance
        do_op(1, rand128(), 1'b0, 0, 1'b0, 1'b1, r2);
        do_op(3, rand128(), 1'b1, 0, 1'b0, 1'b1, r2);
        st = rand128();
        do_op(5, st, 1'b1, 0, 1'b0, 1'b0, r2);
        chk("fwd_only", r2, model(st, 1'b0));

        // Throughput with out_ready tied high, then random regression
        for (int d = 0; d < ND; d++) stream(d, 8, 1'b0);
        for (int d = 0; d < 5; d++) stream(d, 200, 1'b1);
        stream(5, 50, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
